// File: rtl/mux_pkg.sv
// Shared constants and helpers for the rr_mux_n selector.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for n channels; a single channel still needs a 1-bit index.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester at or after ptr, wrapping.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic found;

    // Two linear passes: indices >= ptr first, then the wrapped part below ptr.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// N-channel registered selector, fixed-select or round-robin, valid/ready on all sides.
// Optional sticky out-of-range select flag: define RR_MUX_ERR_EN.
module rr_mux_n
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = clog2_min1(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_chan,
    output logic               out_valid,
    input  logic               out_ready
`ifdef RR_MUX_ERR_EN
    ,
    output logic               sel_err
`endif
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [N-1:0]     rr_gnt;
    logic [N-1:0]     fixed_gnt;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             load;
    logic             xfer;

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .req (in_valid),
        .ptr (rr_ptr_q),
        .gnt (rr_gnt)
    );

    // An out-of-range sel matches no channel, so the fixed grant is naturally zero.
    always_comb begin
        fixed_gnt = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) fixed_gnt[i] = in_valid[i];
        end
    end

    assign grant    = (mode == MODE_RR) ? rr_gnt : fixed_gnt;
    assign load     = !out_valid_q || out_ready;
    assign in_ready = (reset_n && load) ? grant : '0;
    assign xfer     = |in_ready;

    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                gnt_idx  = SEL_W'(i);
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = gnt_data;
            out_chan_d  = gnt_idx;
            out_valid_d = 1'b1;
            rr_ptr_d    = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + SEL_W'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

`ifdef RR_MUX_ERR_EN
    logic sel_in_range;
    logic sel_err_q, sel_err_d;

    always_comb begin
        sel_in_range = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) sel_in_range = 1'b1;
        end
    end

    assign sel_err_d = sel_err_q || ((mode == MODE_FIXED) && !sel_in_range);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sel_err_q <= 1'b0;
        else          sel_err_q <= sel_err_d;
    end

    assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_rr_mux_n.sv
// Bench for rr_mux_n: an N=4 and an N=3 instance checked every cycle against a behavioural model.
module tb_rr_mux_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         mode      [2];
    logic [1:0]   sel       [2];
    logic [127:0] in_data   [2];
    logic [3:0]   in_valid  [2];
    logic         out_ready [2];

    logic [3:0]   rdy4;
    logic [2:0]   rdy3;
    logic [31:0]  od [2];
    logic [1:0]   oc [2];
    logic         ov [2];
`ifdef RR_MUX_ERR_EN
    logic         err_w [2];
`endif

    rr_mux_n #(.WIDTH(32), .N(4)) dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode[0]),
        .sel       (sel[0]),
        .in_data   (in_data[0]),
        .in_valid  (in_valid[0]),
        .in_ready  (rdy4),
        .out_data  (od[0]),
        .out_chan  (oc[0]),
        .out_valid (ov[0]),
        .out_ready (out_ready[0])
`ifdef RR_MUX_ERR_EN
        ,
        .sel_err   (err_w[0])
`endif
    );

    rr_mux_n #(.WIDTH(32), .N(3)) dut3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode[1]),
        .sel       (sel[1]),
        .in_data   (in_data[1][95:0]),
        .in_valid  (in_valid[1][2:0]),
        .in_ready  (rdy3),
        .out_data  (od[1]),
        .out_chan  (oc[1]),
        .out_valid (ov[1]),
        .out_ready (out_ready[1])
`ifdef RR_MUX_ERR_EN
        ,
        .sel_err   (err_w[1])
`endif
    );

    // Behavioural model state per instance.
    int          nch [2] = '{4, 3};
    bit          m_valid [2];
    logic [31:0] m_data  [2];
    int          m_chan  [2];
    int          m_ptr   [2];
    bit          m_err   [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] rdy(input int d);
        return (d == 0) ? rdy4 : {1'b0, rdy3};
    endfunction

    // Channel that should win this cycle, or -1 for none.
    function automatic int exp_grant(input int n, input int ptr, input bit md,
                                     input int s, input logic [3:0] v);
        if (md == 1'b0) return (s < n && v[s]) ? s : -1;
        for (int k = 0; k < n; k++) begin
            if (v[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_chan[d]  = 0;
            m_ptr[d]   = 0;
            m_err[d]   = 1'b0;
        end
    endtask

    task automatic settle_check();
        int         g;
        bit         ld;
        logic [3:0] er;
        #2;
        for (int d = 0; d < 2; d++) begin
            g  = exp_grant(nch[d], m_ptr[d], mode[d], int'(sel[d]), in_valid[d]);
            ld = !m_valid[d] || out_ready[d];
            er = (reset_n && ld && g >= 0) ? 4'(1 << g) : 4'h0;
            chk($sformatf("in_ready[%0d]", d), 32'(rdy(d)), 32'(er));
            chk($sformatf("out_valid[%0d]", d), 32'(ov[d]), 32'(m_valid[d]));
            chk($sformatf("out_data[%0d]", d), od[d], m_data[d]);
            chk($sformatf("out_chan[%0d]", d), 32'(oc[d]), 32'(m_chan[d]));
`ifdef RR_MUX_ERR_EN
            chk($sformatf("sel_err[%0d]", d), 32'(err_w[d]), 32'(m_err[d]));
`endif
        end
    endtask

    task automatic tick();
        int g;
        bit ld;
        @(posedge clk);
        if (reset_n) begin
            for (int d = 0; d < 2; d++) begin
                g  = exp_grant(nch[d], m_ptr[d], mode[d], int'(sel[d]), in_valid[d]);
                ld = !m_valid[d] || out_ready[d];
                if (ld && g >= 0) begin
                    m_data[d]  = in_data[d][g*32 +: 32];
                    m_chan[d]  = g;
                    m_valid[d] = 1'b1;
                    m_ptr[d]   = (g + 1) % nch[d];
                end else if (out_ready[d]) begin
                    m_valid[d] = 1'b0;
                end
                if (mode[d] == 1'b0 && int'(sel[d]) >= nch[d]) m_err[d] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic step();
        settle_check();
        tick();
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            mode[d] = 1'b1; sel[d] = '0; in_data[d] = '0;
            in_valid[d] = 4'hF; out_ready[d] = 1'b1;
        end
        in_valid[1] = 4'h7;

        // Reset: nothing granted, output empty.
        for (int c = 0; c < 2; c++) begin
            settle_check();
            chk("rst_in_ready", 32'(rdy4), 32'h0);
            chk("rst_out_valid", 32'(ov[0]), 32'h0);
            chk("rst_out_data", od[0], 32'h0);
            tick();
        end
        reset_n = 1'b1;
        in_valid[0] = 4'h0; in_valid[1] = 4'h0;
        step();

        // Fixed select of channel 2.
        mode[0] = 1'b0; sel[0] = 2'd2;
        in_data[0][64 +: 32] = 32'hDEAD_BEEF;
        in_valid[0] = 4'b0100;
        settle_check();
        chk("fix_in_ready", 32'(rdy4), 32'h4);
        tick();
        in_valid[0] = 4'h0; out_ready[0] = 1'b0;
        chk("fix_out_valid", 32'(ov[0]), 32'h1);
        chk("fix_out_data", od[0], 32'hDEAD_BEEF);
        chk("fix_out_chan", 32'(oc[0]), 32'h2);
        step();

        // Reset while a word is pending: it is dropped.
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("drop_out_valid", 32'(ov[0]), 32'h0);
        chk("drop_out_data", od[0], 32'h0);
        tick();
        reset_n = 1'b1;

        // Round-robin, all valid: back-to-back rotation on both instances.
        for (int d = 0; d < 2; d++) begin
            mode[d] = 1'b1; out_ready[d] = 1'b1;
            for (int i = 0; i < 4; i++) in_data[d][i*32 +: 32] = 32'(i);
        end
        in_valid[0] = 4'hF; in_valid[1] = 4'h7;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr4_chan", 32'(oc[0]), 32'(i % 4));
            chk("rr4_data", od[0], 32'(i % 4));
            chk("rr4_valid", 32'(ov[0]), 32'h1);
            chk("rr3_chan", 32'(oc[1]), 32'(i % 3));
        end

        // Backpressure holds the word and blocks inputs; release loads next grant at once.
        out_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle_check();
            chk("bp_in_ready", 32'(rdy4), 32'h0);
            tick();
            chk("bp_out_chan", 32'(oc[0]), 32'h0);
            chk("bp_out_valid", 32'(ov[0]), 32'h1);
        end
        out_ready[0] = 1'b1;
        settle_check();
        chk("bp_release_ready", 32'(rdy4), 32'h2);
        tick();
        chk("bp_release_chan", 32'(oc[0]), 32'h1);

        // Pointer to 3, then skip over idle channels with wrap.
        in_valid[0] = 4'b0100;
        step();
        in_valid[0] = 4'b1001;
        step(); chk("wrap_chan_a", 32'(oc[0]), 32'h3);
        step(); chk("wrap_chan_b", 32'(oc[0]), 32'h0);
        step(); chk("wrap_chan_c", 32'(oc[0]), 32'h3);

`ifdef RR_MUX_ERR_EN
        // Out-of-range select on the 3-channel instance.
        mode[1] = 1'b0; sel[1] = 2'd3; in_valid[1] = 4'h7; out_ready[1] = 1'b1;
        settle_check();
        chk("err_in_ready", 32'(rdy3), 32'h0);
        tick();
        chk("err_set", 32'(err_w[1]), 32'h1);
        sel[1] = 2'd0;
        step(); chk("err_sticky_a", 32'(err_w[1]), 32'h1);
        step(); chk("err_sticky_b", 32'(err_w[1]), 32'h1);
        pulse_reset();
        chk("err_cleared", 32'(err_w[1]), 32'h0);
`endif

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
            end
            for (int d = 0; d < 2; d++) begin
                mode[d]      = 1'($urandom_range(0, 1));
                sel[d]       = 2'($urandom_range(0, 3));
                in_valid[d]  = 4'($urandom_range(0, 15));
                out_ready[d] = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < 4; i++) in_data[d][i*32 +: 32] = $urandom;
            end
            in_valid[1][3] = 1'b0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
